// File: rtl/lab4_rom_reader.sv
// Burst reader for the lab4 ROM: fetches COUNT consecutive words and streams them on valid/ready.
// Define LAB4_READER_CHECKSUM_EN to build the running checksum; otherwise checksum is tied to 0.
module lab4_rom_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 5
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [DATA_W-1:0] romData,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} stateT;

    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    stateT           state, stateNext;
    logic [ADDR_W:0] remaining;
    logic            accept;

    assign accept = (state == SEND) && outReady;
    assign busy   = (state != IDLE);
    assign done   = (state == FIN);

    always_ff @(posedge CLK) begin
        if (!RESETn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = FETCH;
            FETCH:   stateNext = SEND;
            SEND:    if (outReady) stateNext = (remaining == ONE_CNT) ? FIN : FETCH;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // romAddr is only moved on start and on acceptance, so it idles at last+1.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            romAddr   <= '0;
            outData   <= '0;
            outValid  <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    romAddr   <= startAddr;
                    remaining <= (count == '0) ? FULL_CNT : count;
                end
                FETCH: begin
                    outData  <= romData;
                    outValid <= 1'b1;
                end
                SEND: if (outReady) begin
                    outValid  <= 1'b0;
                    remaining <= remaining - ONE_CNT;
                    romAddr   <= romAddr + ONE_ADDR;
                end
                default: ;
            endcase
        end
    end

`ifdef LAB4_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sumReg;

    // Cleared on burst start, not on FIN, so the result stays readable in IDLE.
    always_ff @(posedge CLK) begin
        if (!RESETn)                      sumReg <= '0;
        else if (state == IDLE && start)  sumReg <= '0;
        else if (accept)                  sumReg <= sumReg + outData;
    end

    assign checksum = sumReg;
`else
    assign checksum = '0;
`endif

endmodule
